// File: rtl/fetcher.sv
// Instruction fetch stage: holds the pc, looks it up in a direct-mapped
// one-word-per-line instruction cache and refills misses from the memory arbiter.
module fetcher #(
    parameter int INDEX_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        has_misbranch,
    input  logic [31:0] in_branch_pc,
    output logic        out_mem_ask,
    output logic [31:0] out_mem_addr,
    input  logic        in_mem_ready,
    input  logic [31:0] in_mem_inst,
    input  logic        in_queue_full,
    output logic        out_inst_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 30 - INDEX_W;

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        mem_ask_q, mem_ask_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;

    logic [LINES-1:0] line_valid_q;
    logic [TAG_W-1:0] line_tag_q  [LINES];
    logic [31:0]      line_data_q [LINES];

    logic [INDEX_W-1:0] look_idx;
    logic [TAG_W-1:0]   look_tag;
    logic               look_hit;
    logic               fill_we;
    logic [INDEX_W-1:0] fill_idx;
    logic [TAG_W-1:0]   fill_tag;

    assign look_idx = pc_q[INDEX_W+1:2];
    assign look_tag = pc_q[31:INDEX_W+2];
    assign look_hit = line_valid_q[look_idx] && (line_tag_q[look_idx] == look_tag);

    // The refill always targets the line of the outstanding request address.
    assign fill_idx = mem_addr_q[INDEX_W+1:2];
    assign fill_tag = mem_addr_q[31:INDEX_W+2];

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        mem_ask_d    = mem_ask_q;
        mem_addr_d   = mem_addr_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        fill_we      = 1'b0;

        if (has_misbranch) begin
            pc_d         = in_branch_pc & ~32'd3;
            state_d      = IDLE;
            mem_ask_d    = 1'b0;
            inst_valid_d = 1'b0;
        end else if (rdy) begin
            mem_ask_d    = 1'b0;
            inst_valid_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (!in_queue_full) begin
                        if (look_hit) begin
                            inst_valid_d = 1'b1;
                            inst_d       = line_data_q[look_idx];
                            inst_pc_d    = pc_q;
                            pc_d         = pc_q + 32'd4;
                        end else begin
                            mem_ask_d  = 1'b1;
                            mem_addr_d = pc_q;
                            state_d    = WAIT_MEM;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (in_mem_ready) begin
                        fill_we = 1'b1;
                        state_d = IDLE;
                        // With the queue full the word is only cached; the next IDLE lookup hits.
                        if (!in_queue_full) begin
                            inst_valid_d = 1'b1;
                            inst_d       = in_mem_inst;
                            inst_pc_d    = pc_q;
                            pc_d         = pc_q + 32'd4;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= 32'd0;
            mem_ask_q    <= 1'b0;
            mem_addr_q   <= 32'd0;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'd0;
            inst_pc_q    <= 32'd0;
            line_valid_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            mem_ask_q    <= mem_ask_d;
            mem_addr_q   <= mem_addr_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            if (fill_we) begin
                line_valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // Tag and data need no reset: they are only read behind a valid bit.
    always_ff @(posedge clk) begin
        if (!rst && fill_we) begin
            line_tag_q[fill_idx]  <= fill_tag;
            line_data_q[fill_idx] <= in_mem_inst;
        end
    end

    assign out_mem_ask    = mem_ask_q;
    assign out_mem_addr   = mem_addr_q;
    assign out_inst_valid = inst_valid_q;
    assign out_inst       = inst_q;
    assign out_pc         = inst_pc_q;

endmodule
